// File: rtl/axi4_arbiter_2to1.sv
// 2:1 AXI4 arbiter: independent write and read paths, one outstanding transaction per path.
// Build option: define AXI_ARB_FIXED_PRIO_EN for fixed s0 priority instead of round-robin.
module axi4_arbiter_2to1 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     s0_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic [7:0]              s0_axi_awlen,
    input  logic [2:0]              s0_axi_awsize,
    input  logic [1:0]              s0_axi_awburst,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wlast,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [ID_WIDTH-1:0]     s0_axi_bid,
    output logic [1:0]              s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ID_WIDTH-1:0]     s0_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic [7:0]              s0_axi_arlen,
    input  logic [2:0]              s0_axi_arsize,
    input  logic [1:0]              s0_axi_arburst,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [ID_WIDTH-1:0]     s0_axi_rid,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [1:0]              s0_axi_rresp,
    output logic                    s0_axi_rlast,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready,
    input  logic [ID_WIDTH-1:0]     s1_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic [7:0]              s1_axi_awlen,
    input  logic [2:0]              s1_axi_awsize,
    input  logic [1:0]              s1_axi_awburst,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wlast,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic [ID_WIDTH-1:0]     s1_axi_bid,
    output logic [1:0]              s1_axi_bresp,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    input  logic [ID_WIDTH-1:0]     s1_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic [7:0]              s1_axi_arlen,
    input  logic [2:0]              s1_axi_arsize,
    input  logic [1:0]              s1_axi_arburst,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [ID_WIDTH-1:0]     s1_axi_rid,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic [1:0]              s1_axi_rresp,
    output logic                    s1_axi_rlast,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;

    w_state_t w_state_r, w_state_s;
    r_state_t r_state_r, r_state_s;
    logic     wgnt_r, wgnt_s, rgnt_r, rgnt_s;
    logic     w_pick_s, r_pick_s, aw_req_s, ar_req_s;
    logic     sel_awvalid_s, sel_wvalid_s, sel_wlast_s, sel_bready_s, sel_arvalid_s, sel_rready_s;

    assign aw_req_s = s0_axi_awvalid | s1_axi_awvalid;
    assign ar_req_s = s0_axi_arvalid | s1_axi_arvalid;

`ifdef AXI_ARB_FIXED_PRIO_EN
    assign w_pick_s = ~s0_axi_awvalid;
    assign r_pick_s = ~s0_axi_arvalid;
`else
    logic w_last_r, r_last_r;

    // A tie goes to whichever requester was not granted last on that path
    assign w_pick_s = (s0_axi_awvalid & s1_axi_awvalid) ? ~w_last_r : s1_axi_awvalid;
    assign r_pick_s = (s0_axi_arvalid & s1_axi_arvalid) ? ~r_last_r : s1_axi_arvalid;

    // Round-robin history, updated on every grant
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_last_r <= 1'b1;
            r_last_r <= 1'b1;
        end else begin
            w_last_r <= (w_state_r == W_IDLE && aw_req_s) ? w_pick_s : w_last_r;
            r_last_r <= (r_state_r == R_IDLE && ar_req_s) ? r_pick_s : r_last_r;
        end
    end
`endif

    assign sel_awvalid_s = wgnt_r ? s1_axi_awvalid : s0_axi_awvalid;
    assign sel_wvalid_s  = wgnt_r ? s1_axi_wvalid  : s0_axi_wvalid;
    assign sel_wlast_s   = wgnt_r ? s1_axi_wlast   : s0_axi_wlast;
    assign sel_bready_s  = wgnt_r ? s1_axi_bready  : s0_axi_bready;
    assign sel_arvalid_s = rgnt_r ? s1_axi_arvalid : s0_axi_arvalid;
    assign sel_rready_s  = rgnt_r ? s1_axi_rready  : s0_axi_rready;

    assign m_axi_awid    = wgnt_r ? s1_axi_awid    : s0_axi_awid;
    assign m_axi_awaddr  = wgnt_r ? s1_axi_awaddr  : s0_axi_awaddr;
    assign m_axi_awlen   = wgnt_r ? s1_axi_awlen   : s0_axi_awlen;
    assign m_axi_awsize  = wgnt_r ? s1_axi_awsize  : s0_axi_awsize;
    assign m_axi_awburst = wgnt_r ? s1_axi_awburst : s0_axi_awburst;
    assign m_axi_wdata   = wgnt_r ? s1_axi_wdata   : s0_axi_wdata;
    assign m_axi_wstrb   = wgnt_r ? s1_axi_wstrb   : s0_axi_wstrb;
    assign m_axi_wlast   = sel_wlast_s;
    assign m_axi_arid    = rgnt_r ? s1_axi_arid    : s0_axi_arid;
    assign m_axi_araddr  = rgnt_r ? s1_axi_araddr  : s0_axi_araddr;
    assign m_axi_arlen   = rgnt_r ? s1_axi_arlen   : s0_axi_arlen;
    assign m_axi_arsize  = rgnt_r ? s1_axi_arsize  : s0_axi_arsize;
    assign m_axi_arburst = rgnt_r ? s1_axi_arburst : s0_axi_arburst;

    // Response payloads are broadcast; only the granted side ever sees valid
    assign s0_axi_bid   = m_axi_bid;
    assign s0_axi_bresp = m_axi_bresp;
    assign s1_axi_bid   = m_axi_bid;
    assign s1_axi_bresp = m_axi_bresp;
    assign s0_axi_rid   = m_axi_rid;
    assign s0_axi_rdata = m_axi_rdata;
    assign s0_axi_rresp = m_axi_rresp;
    assign s0_axi_rlast = m_axi_rlast;
    assign s1_axi_rid   = m_axi_rid;
    assign s1_axi_rdata = m_axi_rdata;
    assign s1_axi_rresp = m_axi_rresp;
    assign s1_axi_rlast = m_axi_rlast;

    // Write and read state/grant registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state_r <= W_IDLE;
            wgnt_r    <= 1'b0;
            r_state_r <= R_IDLE;
            rgnt_r    <= 1'b0;
        end else begin
            w_state_r <= w_state_s;
            wgnt_r    <= wgnt_s;
            r_state_r <= r_state_s;
            rgnt_r    <= rgnt_s;
        end
    end

    // Write path next state and handshake routing
    always_comb begin
        w_state_s      = w_state_r;
        wgnt_s         = wgnt_r;
        m_axi_awvalid  = 1'b0;
        m_axi_wvalid   = 1'b0;
        m_axi_bready   = 1'b0;
        s0_axi_awready = 1'b0;
        s1_axi_awready = 1'b0;
        s0_axi_wready  = 1'b0;
        s1_axi_wready  = 1'b0;
        s0_axi_bvalid  = 1'b0;
        s1_axi_bvalid  = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (aw_req_s) begin
                    wgnt_s    = w_pick_s;
                    w_state_s = W_ADDR;
                end else begin
                    w_state_s = W_IDLE;
                end
            end
            W_ADDR: begin
                m_axi_awvalid  = sel_awvalid_s;
                s0_axi_awready = ~wgnt_r & m_axi_awready;
                s1_axi_awready = wgnt_r & m_axi_awready;
                w_state_s      = (sel_awvalid_s & m_axi_awready) ? W_DATA : W_ADDR;
            end
            W_DATA: begin
                m_axi_wvalid  = sel_wvalid_s;
                s0_axi_wready = ~wgnt_r & m_axi_wready;
                s1_axi_wready = wgnt_r & m_axi_wready;
                w_state_s     = (sel_wvalid_s & m_axi_wready & sel_wlast_s) ? W_RESP : W_DATA;
            end
            W_RESP: begin
                m_axi_bready  = sel_bready_s;
                s0_axi_bvalid = ~wgnt_r & m_axi_bvalid;
                s1_axi_bvalid = wgnt_r & m_axi_bvalid;
                w_state_s     = (m_axi_bvalid & sel_bready_s) ? W_IDLE : W_RESP;
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Read path next state and handshake routing
    always_comb begin
        r_state_s      = r_state_r;
        rgnt_s         = rgnt_r;
        m_axi_arvalid  = 1'b0;
        m_axi_rready   = 1'b0;
        s0_axi_arready = 1'b0;
        s1_axi_arready = 1'b0;
        s0_axi_rvalid  = 1'b0;
        s1_axi_rvalid  = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                if (ar_req_s) begin
                    rgnt_s    = r_pick_s;
                    r_state_s = R_ADDR;
                end else begin
                    r_state_s = R_IDLE;
                end
            end
            R_ADDR: begin
                m_axi_arvalid  = sel_arvalid_s;
                s0_axi_arready = ~rgnt_r & m_axi_arready;
                s1_axi_arready = rgnt_r & m_axi_arready;
                r_state_s      = (sel_arvalid_s & m_axi_arready) ? R_DATA : R_ADDR;
            end
            R_DATA: begin
                m_axi_rready  = sel_rready_s;
                s0_axi_rvalid = ~rgnt_r & m_axi_rvalid;
                s1_axi_rvalid = rgnt_r & m_axi_rvalid;
                r_state_s     = (m_axi_rvalid & sel_rready_s & m_axi_rlast) ? R_IDLE : R_DATA;
            end
            default: r_state_s = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_arbiter_2to1.sv
// Randomized bench for axi4_arbiter_2to1: bench acts as both requesters and the downstream slave,
// predicting grant order from the arbitration rules and checking routing, payloads and latency.
module tb_axi4_arbiter_2to1;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int SW = DW / 8;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [IW-1:0] s_awid [2];
    logic [AW-1:0] s_awaddr [2];
    logic [7:0]    s_awlen [2];
    logic [2:0]    s_awsize [2];
    logic [1:0]    s_awburst [2];
    logic          s_awvalid [2];
    logic          s_awready [2];
    logic [DW-1:0] s_wdata [2];
    logic [SW-1:0] s_wstrb [2];
    logic          s_wlast [2];
    logic          s_wvalid [2];
    logic          s_wready [2];
    logic [IW-1:0] s_bid [2];
    logic [1:0]    s_bresp [2];
    logic          s_bvalid [2];
    logic          s_bready [2];
    logic [IW-1:0] s_arid [2];
    logic [AW-1:0] s_araddr [2];
    logic [7:0]    s_arlen [2];
    logic [2:0]    s_arsize [2];
    logic [1:0]    s_arburst [2];
    logic          s_arvalid [2];
    logic          s_arready [2];
    logic [IW-1:0] s_rid [2];
    logic [DW-1:0] s_rdata [2];
    logic [1:0]    s_rresp [2];
    logic          s_rlast [2];
    logic          s_rvalid [2];
    logic          s_rready [2];

    logic [IW-1:0] m_awid, m_arid, m_bid, m_rid;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [7:0]    m_awlen, m_arlen;
    logic [2:0]    m_awsize, m_arsize;
    logic [1:0]    m_awburst, m_arburst, m_bresp, m_rresp;
    logic          m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
    logic          m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_wstrb;

    axi4_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_axi_awid(s_awid[0]), .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awlen(s_awlen[0]),
        .s0_axi_awsize(s_awsize[0]), .s0_axi_awburst(s_awburst[0]), .s0_axi_awvalid(s_awvalid[0]),
        .s0_axi_awready(s_awready[0]), .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]),
        .s0_axi_wlast(s_wlast[0]), .s0_axi_wvalid(s_wvalid[0]), .s0_axi_wready(s_wready[0]),
        .s0_axi_bid(s_bid[0]), .s0_axi_bresp(s_bresp[0]), .s0_axi_bvalid(s_bvalid[0]),
        .s0_axi_bready(s_bready[0]), .s0_axi_arid(s_arid[0]), .s0_axi_araddr(s_araddr[0]),
        .s0_axi_arlen(s_arlen[0]), .s0_axi_arsize(s_arsize[0]), .s0_axi_arburst(s_arburst[0]),
        .s0_axi_arvalid(s_arvalid[0]), .s0_axi_arready(s_arready[0]), .s0_axi_rid(s_rid[0]),
        .s0_axi_rdata(s_rdata[0]), .s0_axi_rresp(s_rresp[0]), .s0_axi_rlast(s_rlast[0]),
        .s0_axi_rvalid(s_rvalid[0]), .s0_axi_rready(s_rready[0]),
        .s1_axi_awid(s_awid[1]), .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awlen(s_awlen[1]),
        .s1_axi_awsize(s_awsize[1]), .s1_axi_awburst(s_awburst[1]), .s1_axi_awvalid(s_awvalid[1]),
        .s1_axi_awready(s_awready[1]), .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]),
        .s1_axi_wlast(s_wlast[1]), .s1_axi_wvalid(s_wvalid[1]), .s1_axi_wready(s_wready[1]),
        .s1_axi_bid(s_bid[1]), .s1_axi_bresp(s_bresp[1]), .s1_axi_bvalid(s_bvalid[1]),
        .s1_axi_bready(s_bready[1]), .s1_axi_arid(s_arid[1]), .s1_axi_araddr(s_araddr[1]),
        .s1_axi_arlen(s_arlen[1]), .s1_axi_arsize(s_arsize[1]), .s1_axi_arburst(s_arburst[1]),
        .s1_axi_arvalid(s_arvalid[1]), .s1_axi_arready(s_arready[1]), .s1_axi_rid(s_rid[1]),
        .s1_axi_rdata(s_rdata[1]), .s1_axi_rresp(s_rresp[1]), .s1_axi_rlast(s_rlast[1]),
        .s1_axi_rvalid(s_rvalid[1]), .s1_axi_rready(s_rready[1]),
        .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize),
        .m_axi_awburst(m_awburst), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast), .m_axi_wvalid(m_wvalid),
        .m_axi_wready(m_wready), .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid),
        .m_axi_bready(m_bready), .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
        .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arvalid(m_arvalid),
        .m_axi_arready(m_arready), .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp),
        .m_axi_rlast(m_rlast), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
    );

    int checks = 0;
    int failures = 0;
    bit w_last_m = 1'b1;
    bit r_last_m = 1'b1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Winner of a simultaneous request given the path's previous winner
    function automatic int tie_winner(input bit last);
`ifdef AXI_ARB_FIXED_PRIO_EN
        return (last & 1'b0) ? 1 : 0;
`else
        return last ? 0 : 1;
`endif
    endfunction

    task automatic idle_write();
        for (int n = 0; n < 2; n++) begin
            s_awid[n] = '0; s_awaddr[n] = '0; s_awlen[n] = '0; s_awsize[n] = '0; s_awburst[n] = '0;
            s_awvalid[n] = 1'b0; s_wdata[n] = '0; s_wstrb[n] = '0; s_wlast[n] = 1'b0;
            s_wvalid[n] = 1'b0; s_bready[n] = 1'b0;
        end
        m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    endtask

    task automatic idle_read();
        for (int n = 0; n < 2; n++) begin
            s_arid[n] = '0; s_araddr[n] = '0; s_arlen[n] = '0; s_arsize[n] = '0; s_arburst[n] = '0;
            s_arvalid[n] = 1'b0; s_rready[n] = 1'b0;
        end
        m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_eq(tag, {s_awready[0], s_awready[1], s_wready[0], s_wready[1], s_bvalid[0], s_bvalid[1],
                       s_arready[0], s_arready[1], s_rvalid[0], s_rvalid[1],
                       m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'd0);
    endtask

    // One write round: requesters in mask issue one burst each; entered and left on a negedge
    task automatic write_round(input bit [1:0] mask);
        int order[$];
        int owner, phase, cyc, exp_rise, f;
        bit aw_seen;
        bit aw_pend [2];
        bit w_pend [2];
        int beat [2];
        logic [IW-1:0] id [2];
        logic [AW-1:0] addr [2];
        logic [7:0]    len [2];
        logic [1:0]    burst [2];
        logic [1:0]    bresp [2];
        logic [DW-1:0] data [2][4];
        logic [SW-1:0] strb [2][4];
        for (int n = 0; n < 2; n++) begin
            aw_pend[n] = mask[n]; w_pend[n] = mask[n]; beat[n] = 0;
            id[n] = IW'($urandom); addr[n] = $urandom; len[n] = 8'($urandom_range(0, 3));
            burst[n] = 2'($urandom_range(0, 2)); bresp[n] = 2'($urandom);
            for (int b = 0; b < 4; b++) begin data[n][b] = $urandom; strb[n][b] = SW'($urandom); end
        end
        if (mask == 2'b11) begin
            f = tie_winner(w_last_m);
            order.push_back(f); order.push_back(1 - f);
        end else begin
            order.push_back(mask[1] ? 1 : 0);
        end
        w_last_m = (order[order.size() - 1] == 1);
        owner = order[0]; phase = 0; cyc = 0; exp_rise = 1; aw_seen = 1'b0;
        while (order.size() != 0 && cyc < 400) begin
            for (int n = 0; n < 2; n++) begin
                s_awvalid[n] = aw_pend[n]; s_awid[n] = id[n]; s_awaddr[n] = addr[n]; s_awlen[n] = len[n];
                s_awsize[n] = 3'd2; s_awburst[n] = burst[n];
                s_wvalid[n] = w_pend[n]; s_wdata[n] = data[n][beat[n]]; s_wstrb[n] = strb[n][beat[n]];
                s_wlast[n] = (beat[n] == int'(len[n])); s_bready[n] = 1'($urandom_range(0, 1));
            end
            m_awready = 1'($urandom_range(0, 1)); m_wready = 1'($urandom_range(0, 1));
            m_bvalid = (phase == 2); m_bid = id[owner]; m_bresp = bresp[owner];
            #1;
            check_eq("w_other_quiet", {s_awready[1 - owner], s_wready[1 - owner], s_bvalid[1 - owner]}, 64'd0);
            if (phase == 0) begin
                check_eq("w_not_before_aw", m_wvalid, 64'd0);
                if (m_awvalid && !aw_seen) begin
                    aw_seen = 1'b1;
                    check_eq("aw_latency", cyc, exp_rise);
                end
                if (m_awvalid && m_awready) begin
                    check_eq("aw_fields", {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst},
                             {id[owner], addr[owner], len[owner], 3'd2, burst[owner]});
                    check_eq("aw_ready_route", s_awready[owner], 64'd1);
                    aw_pend[owner] = 1'b0; phase = 1;
                end
            end else if (phase == 1) begin
                check_eq("aw_idle_in_data", m_awvalid, 64'd0);
                if (m_wvalid && m_wready) begin
                    check_eq("w_beat", {m_wdata, m_wstrb, m_wlast, s_wready[owner]},
                             {data[owner][beat[owner]], strb[owner][beat[owner]],
                              1'(beat[owner] == int'(len[owner])), 1'b1});
                    if (beat[owner] == int'(len[owner])) begin
                        w_pend[owner] = 1'b0; phase = 2;
                    end else begin
                        beat[owner]++;
                    end
                end
            end else begin
                if (s_bvalid[owner] && s_bready[owner]) begin
                    check_eq("b_route", {s_bid[owner], s_bresp[owner], m_bready}, {id[owner], bresp[owner], 1'b1});
                    void'(order.pop_front());
                    if (order.size() != 0) begin
                        owner = order[0]; phase = 0; aw_seen = 1'b0; exp_rise = cyc + 2;
                    end
                end
            end
            cyc++;
            @(negedge aclk);
        end
        check_eq("w_round_done", order.size(), 64'd0);
        idle_write();
    endtask

    // One read round: requesters in mask issue one burst each; entered and left on a negedge
    task automatic read_round(input bit [1:0] mask);
        int order[$];
        int owner, phase, cyc, exp_rise, f;
        bit ar_seen;
        bit ar_pend [2];
        int beat [2];
        logic [IW-1:0] id [2];
        logic [AW-1:0] addr [2];
        logic [7:0]    len [2];
        logic [1:0]    burst [2];
        logic [1:0]    rresp [2];
        logic [DW-1:0] data [2][4];
        for (int n = 0; n < 2; n++) begin
            ar_pend[n] = mask[n]; beat[n] = 0;
            id[n] = IW'($urandom); addr[n] = $urandom; len[n] = 8'($urandom_range(0, 3));
            burst[n] = 2'($urandom_range(0, 2)); rresp[n] = 2'($urandom);
            for (int b = 0; b < 4; b++) data[n][b] = $urandom;
        end
        if (mask == 2'b11) begin
            f = tie_winner(r_last_m);
            order.push_back(f); order.push_back(1 - f);
        end else begin
            order.push_back(mask[1] ? 1 : 0);
        end
        r_last_m = (order[order.size() - 1] == 1);
        owner = order[0]; phase = 0; cyc = 0; exp_rise = 1; ar_seen = 1'b0;
        while (order.size() != 0 && cyc < 400) begin
            for (int n = 0; n < 2; n++) begin
                s_arvalid[n] = ar_pend[n]; s_arid[n] = id[n]; s_araddr[n] = addr[n]; s_arlen[n] = len[n];
                s_arsize[n] = 3'd2; s_arburst[n] = burst[n]; s_rready[n] = 1'($urandom_range(0, 1));
            end
            m_arready = 1'($urandom_range(0, 1));
            m_rvalid = (phase == 1); m_rid = id[owner]; m_rdata = data[owner][beat[owner]];
            m_rresp = rresp[owner]; m_rlast = (beat[owner] == int'(len[owner]));
            #1;
            check_eq("r_other_quiet", {s_arready[1 - owner], s_rvalid[1 - owner]}, 64'd0);
            if (phase == 0) begin
                check_eq("rready_idle_in_addr", m_rready, 64'd0);
                if (m_arvalid && !ar_seen) begin
                    ar_seen = 1'b1;
                    check_eq("ar_latency", cyc, exp_rise);
                end
                if (m_arvalid && m_arready) begin
                    check_eq("ar_fields", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst},
                             {id[owner], addr[owner], len[owner], 3'd2, burst[owner]});
                    check_eq("ar_ready_route", s_arready[owner], 64'd1);
                    ar_pend[owner] = 1'b0; phase = 1;
                end
            end else begin
                check_eq("ar_idle_in_data", m_arvalid, 64'd0);
                if (s_rvalid[owner] && s_rready[owner]) begin
                    check_eq("r_beat", {s_rid[owner], s_rdata[owner], s_rresp[owner], s_rlast[owner], m_rready},
                             {id[owner], data[owner][beat[owner]], rresp[owner],
                              1'(beat[owner] == int'(len[owner])), 1'b1});
                    if (beat[owner] == int'(len[owner])) begin
                        void'(order.pop_front());
                        if (order.size() != 0) begin
                            owner = order[0]; phase = 0; ar_seen = 1'b0; exp_rise = cyc + 2;
                        end
                    end else begin
                        beat[owner]++;
                    end
                end
            end
            cyc++;
            @(negedge aclk);
        end
        check_eq("r_round_done", order.size(), 64'd0);
        idle_read();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        idle_write();
        idle_read();
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        check_quiet("reset_state");
        aresetn = 1'b1;
        @(negedge aclk);

        // Two tie rounds straight after reset: downstream order s0, s1, s0, s1
        write_round(2'b11);
        write_round(2'b11);

        fork
            begin
                repeat (30) write_round(2'($urandom_range(1, 3)));
            end
            begin
                repeat (30) read_round(2'($urandom_range(1, 3)));
            end
        join

        // Reset in the middle of a 4-beat write after two beats have been accepted
        s_awvalid[0] = 1'b1; s_awaddr[0] = 32'h0000_1000; s_awlen[0] = 8'd3;
        s_wvalid[0] = 1'b1; s_wdata[0] = 32'hDEAD_BEEF; s_wlast[0] = 1'b0;
        m_awready = 1'b1; m_wready = 1'b1;
        @(negedge aclk);
        #1;
        check_eq("rst_pre_aw", {m_awvalid, m_awaddr}, {1'b1, 32'h0000_1000});
        @(negedge aclk);
        s_awvalid[0] = 1'b0;
        #1;
        check_eq("rst_pre_w", m_wvalid, 64'd1);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        s_wvalid[0] = 1'b0; m_awready = 1'b0;
        s_awvalid[0] = 1'b1; s_awaddr[0] = 32'h0000_A000;
        s_awvalid[1] = 1'b1; s_awaddr[1] = 32'h0000_B000;
        #1;
        check_quiet("rst_quiet");
        @(negedge aclk);
        #1;
        check_eq("rst_tie_s0", {m_awvalid, m_awaddr, s_awready[1]}, {1'b1, 32'h0000_A000, 1'b0});
        aresetn = 1'b0;
        idle_write();
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
